bus_hold_arbiter: RTL and testbench
===================================

// Module: bus_hold_arbiter
// PURPOSE
//  Shares the 8088 local bus (multiplexed AD/A, ALE latch, 8286 transceiver, MEM/IO decode) between the CPU and
//  NREQ bus masters (DMA/test engines). Drives the CPU HOLD pin, waits for HLDA, grants the bus to one master
//  at a time using round-robin, and returns the bus to the CPU for a guaranteed minimum window between tenures.
// PARAMETERS
//  NREQ            4   number of external bus masters (2..8)
//  MIN_CPU_CYCLES  2   CLK cycles the CPU owns the bus after HLDA falls, before next HOLD (>=1)
//  MAX_HOLD_CYCLES 64  tenure limit in CLK cycles; used only when BUS_TENURE_LIMIT_EN is defined
// PORTS
//  CLK      in   1     system clock; all state updates on posedge
//  RESET_N  in   1     asynchronous, active-low reset
//  REQ      in   NREQ  bus request per master; held high for the whole tenure
//  GNT      out  NREQ  one-hot grant; master drives the bus only while its GNT=1
//  HOLD     out  1     to CPU HOLD pin
//  HLDA     in   1     from CPU HLDA pin, synchronous to CLK
//  BUSY     out  1     1 in any state other than IDLE
//  ERR      out  1     one-cycle pulse: HLDA fell while a grant was active
//  TIMEOUT  out  1     one-cycle pulse: tenure forcibly ended (macro only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset (RESET_N=0, async): HOLD=0, GNT=0, BUSY=0, ERR=0, TIMEOUT=0, ptr=0, state=IDLE, gap counter=0.
//  - All outputs registered. States: IDLE, WAIT_HLDA, GRANT, RELEASE, GAP.
//  - IDLE: if |REQ at edge n -> winner = first set REQ bit scanning ptr, ptr+1, ... mod NREQ; latch winner;
//    HOLD=1 and BUSY=1 after edge n; -> WAIT_HLDA.
//  - WAIT_HLDA: HOLD stays 1. HLDA=1 sampled at edge m: if REQ[winner]=1 -> GNT[winner]=1 after edge m, -> GRANT
//    (REQ-to-GNT minimum latency 2 edges); if REQ[winner]=0 (withdrawn) -> no GNT, HOLD=0, -> RELEASE.
//    A withdrawn REQ before HLDA never drops HOLD early (8088 HOLD must stand until HLDA).
//  - GRANT: GNT[winner] held while REQ[winner]=1 and HLDA=1. REQ[winner]=0 at edge -> GNT=0, HOLD=0 after that edge,
//    ptr = (winner+1) mod NREQ, -> RELEASE. Other REQ bits are ignored during GRANT (no preemption).
//  - HLDA=0 while in GRANT (protocol error) -> GNT=0, HOLD=0, ERR=1 for one cycle, ptr advanced, -> RELEASE.
//  - RELEASE: HOLD=0; wait for HLDA=0; on that edge load gap counter with MIN_CPU_CYCLES-1, -> GAP.
//  - GAP: counter decrements each edge; at 0 -> IDLE. REQ ignored during RELEASE/GAP, so the CPU gets
//    >= MIN_CPU_CYCLES of bus between successive HLDA-high periods.
//  - GNT is never asserted unless HOLD=1 and HLDA=1 were both sampled; at most one GNT bit set.
//  - ptr wraps NREQ-1 -> 0. Winner index width = $clog2(NREQ).
//  - RESET_N asserted mid-tenure: GNT and HOLD drop immediately (async); arbitration restarts at ptr=0.
// CONFIGURATION
//  BUS_TENURE_LIMIT_EN defined: tenure counter cleared on entry to GRANT, increments each GRANT cycle; when it
//   reaches MAX_HOLD_CYCLES-1 with REQ still high -> GNT=0, HOLD=0, TIMEOUT=1 one cycle, ptr advanced, -> RELEASE.
//   Counter width $clog2(MAX_HOLD_CYCLES+1). Master must re-request after GAP.
//  Not defined: no counter is built, tenure unlimited, TIMEOUT constant 0.
// TESTING
//  1 Reset: RESET_N=0 mid-GRANT -> HOLD=0, GNT=0 same cycle; after release with REQ=0 outputs stay 0.
//  2 Single master: REQ=4'b0010; CPU model returns HLDA 3 cycles after HOLD -> GNT=4'b0010 one cycle after HLDA;
//    drop REQ -> GNT=0, HOLD=0 next edge; no new HOLD for 2 cycles after HLDA falls.
//  3 Round-robin: REQ=4'b1111 held -> grant order 0,1,2,3,0 with each master dropping REQ after 5 cycles of GNT.
//  4 Withdraw: REQ[2] pulsed 1 cycle in IDLE -> HOLD=1 until HLDA=1, then HOLD=0, GNT never set, ptr unchanged.
//  5 Protocol error: force HLDA=0 during GRANT -> ERR=1 for exactly 1 cycle, GNT=0, state RELEASE then GAP.
//  6 BUS_TENURE_LIMIT_EN, MAX_HOLD_CYCLES=8: REQ[0] held -> GNT[0] high exactly 8 cycles, TIMEOUT pulse,
//    REQ[1] waiting is granted next.

Source files
------------

// File: rtl/bus_hold_arbiter.sv
// ---------------------------------------------------------------------------
// bus_hold_arbiter
//
// Shares the 8088 local bus between the CPU and NREQ external bus masters.
// A request raises the CPU HOLD pin; once HLDA comes back the round-robin
// winner gets a one-hot grant. When the tenure ends the bus goes back to the
// CPU, which then keeps it for at least MIN_CPU_CYCLES clocks before HOLD can
// be raised again.
//
// Handshake (REQ/GNT): a master raises REQ and keeps it high for its whole
// tenure. It may drive the bus only while its GNT bit is 1. Dropping REQ
// while granted ends the tenure at the next edge. Dropping REQ before the
// grant is a withdrawal: HOLD still stands until HLDA answers, then the bus
// is handed straight back to the CPU without a grant.
//
// Optional feature, macro BUS_TENURE_LIMIT_EN:
//   defined     - a tenure is cut after MAX_HOLD_CYCLES cycles of grant and
//                 TIMEOUT pulses for one cycle.
//   not defined - tenure unlimited, TIMEOUT is constant 0.
//
// Ports
//   CLK        in   system clock, posedge
//   RESET_N    in   asynchronous active-low reset
//   REQ        in   [NREQ] bus request per master
//   GNT        out  [NREQ] one-hot grant (registered)
//   HOLD       out  CPU HOLD pin (registered)
//   HLDA       in   CPU HLDA pin, synchronous to CLK
//   BUSY       out  1 whenever the arbiter is not idle (registered)
//   ERR        out  one-cycle pulse: HLDA fell while a grant was active
//   TIMEOUT    out  one-cycle pulse: tenure forcibly ended
//   state_dbg  out  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module bus_hold_arbiter #(
  parameter int NREQ            = 4,
  parameter int MIN_CPU_CYCLES  = 2,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic            HOLD,
  input  logic            HLDA,
  output logic            BUSY,
  output logic            ERR,
  output logic            TIMEOUT,
  output logic [2:0]      state_dbg
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(MIN_CPU_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HLDA = 3'd1,
    S_GRANT     = 3'd2,
    S_RELEASE   = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   winner, winner_nx;
  logic [GW-1:0]   gap_cnt, gap_nx;
  logic [NREQ-1:0] gnt_nx;
  logic            hold_nx, busy_nx, err_nx, timeout_nx;
  logic            scan_hit;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   ptr_after_winner;
  logic            tenure_expired;

  // Index addition modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin scan starting at ptr. Walking the offsets from the far end
  // down to 0 lets the closest set bit to ptr overwrite any later one.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[wrap_add(ptr, i)]) begin
        scan_hit = 1'b1;
        scan_idx = wrap_add(ptr, i);
      end
    end
  end

  assign ptr_after_winner = wrap_add(winner, 1);

`ifdef BUS_TENURE_LIMIT_EN
  localparam int TW = $clog2(MAX_HOLD_CYCLES + 1);
  logic [TW-1:0] ten_cnt;

  // Counts completed GRANT cycles; it is zero on the first grant cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ten_cnt <= '0;
    end else if (state != S_GRANT) begin
      ten_cnt <= '0;
    end else begin
      ten_cnt <= ten_cnt + 1'b1;
    end
  end

  assign tenure_expired = (ten_cnt == TW'(MAX_HOLD_CYCLES - 1));
`else
  // The tenure limit is not built; the parameter stays referenced only so
  // the module interface is identical in both builds.
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD_CYCLES > 0);
  assign tenure_expired  = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    winner_nx  = winner;
    gap_nx     = gap_cnt;
    gnt_nx     = GNT;
    hold_nx    = HOLD;
    err_nx     = 1'b0;
    timeout_nx = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (scan_hit) begin
          winner_nx = scan_idx;
          hold_nx   = 1'b1;
          state_nx  = S_WAIT_HLDA;
        end
      end

      // HOLD must stand until HLDA even if the winner has withdrawn.
      S_WAIT_HLDA: begin
        if (HLDA) begin
          if (REQ[winner]) begin
            gnt_nx         = '0;
            gnt_nx[winner] = 1'b1;
            state_nx       = S_GRANT;
          end else begin
            hold_nx  = 1'b0;
            state_nx = S_RELEASE;
          end
        end
      end

      // Other requests are ignored here: no preemption.
      S_GRANT: begin
        if (!HLDA || !REQ[winner] || tenure_expired) begin
          gnt_nx     = '0;
          hold_nx    = 1'b0;
          ptr_nx     = ptr_after_winner;
          state_nx   = S_RELEASE;
          err_nx     = !HLDA;
          timeout_nx = HLDA && REQ[winner] && tenure_expired;
        end
      end

      S_RELEASE: begin
        if (!HLDA) begin
          gap_nx   = GW'(MIN_CPU_CYCLES - 1);
          state_nx = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          gap_nx = gap_cnt - 1'b1;
        end
      end

      default: begin
        gnt_nx   = '0;
        hold_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      ptr     <= '0;
      winner  <= '0;
      gap_cnt <= '0;
      GNT     <= '0;
      HOLD    <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      winner  <= winner_nx;
      gap_cnt <= gap_nx;
      GNT     <= gnt_nx;
      HOLD    <= hold_nx;
      BUSY    <= busy_nx;
      ERR     <= err_nx;
      TIMEOUT <= timeout_nx;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
module tb_bus_hold_arbiter;

  localparam int NREQ = 4;
  localparam int MINC = 2;
  localparam int MAXH = 8;
`ifdef BUS_TENURE_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            hlda = 1'b0;
  logic [NREQ-1:0] GNT;
  logic            HOLD, BUSY, ERR, TIMEOUT;
  logic [2:0]      state_dbg;

  always #5 CLK = ~CLK;

  bus_hold_arbiter #(
    .NREQ(NREQ), .MIN_CPU_CYCLES(MINC), .MAX_HOLD_CYCLES(MAXH)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req), .GNT(GNT), .HOLD(HOLD),
    .HLDA(hlda), .BUSY(BUSY), .ERR(ERR), .TIMEOUT(TIMEOUT), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  bit force_low = 1'b0;
  bit cpu_rand = 1'b0;
  logic [NREQ-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & NREQ'(1)) != '0;
  endfunction

  // ---------------- CPU model: answers HOLD after dly cycles ----------------
  int cpu_cnt = 0;
  int cpu_dly = 3;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET_N || force_low) begin
        hlda = 1'b0;
        cpu_cnt = 0;
      end else if (HOLD) begin
        if (!hlda) begin
          cpu_cnt++;
          if (cpu_cnt >= cpu_dly) hlda = 1'b1;
        end
      end else begin
        hlda = 1'b0;
        cpu_cnt = 0;
        cpu_dly = cpu_rand ? int'($urandom_range(1, 4)) : 3;
      end
    end
  end

  // ---------------- reference model ----------------
  // Bus ownership is described as: who is waiting for HLDA, who owns the
  // bus, whether the bus is being handed back, and how much CPU time remains.
  int m_owner = -1, m_pending = -1, m_gap = -1, m_ptr = 0, m_ten = 0;
  bit m_hold = 0, m_ret = 0, m_err = 0, m_to = 0, m_busy = 0;

  task automatic model_end_tenure();
    m_ptr   = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_hold  = 1'b0;
    m_ret   = 1'b1;
  endtask

  task automatic model_step();
    if (!RESET_N) begin
      m_owner = -1; m_pending = -1; m_gap = -1; m_ptr = 0; m_ten = 0;
      m_hold = 0; m_ret = 0; m_err = 0; m_to = 0; m_busy = 0;
      return;
    end
    m_err = 1'b0;
    m_to  = 1'b0;
    if (m_gap >= 0) begin
      m_gap = (m_gap == 0) ? -1 : m_gap - 1;
    end else if (m_ret) begin
      if (!hlda) begin
        m_ret = 1'b0;
        m_gap = MINC - 1;
      end
    end else if (m_owner >= 0) begin
      if (!hlda) begin
        m_err = 1'b1;
        model_end_tenure();
      end else if (!bit_of(req, m_owner)) begin
        model_end_tenure();
      end else if (LIMIT && m_ten == MAXH - 1) begin
        m_to = 1'b1;
        model_end_tenure();
      end else begin
        m_ten++;
      end
    end else if (m_pending >= 0) begin
      if (hlda) begin
        if (bit_of(req, m_pending)) begin
          m_owner = m_pending;
          m_ten   = 0;
        end else begin
          m_hold = 1'b0;
          m_ret  = 1'b1;
        end
        m_pending = -1;
      end
    end else if (req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_pending < 0 && bit_of(req, (m_ptr + k) % NREQ)) m_pending = (m_ptr + k) % NREQ;
      end
      m_hold = 1'b1;
    end
    m_busy = (m_pending >= 0) || (m_owner >= 0) || m_ret || (m_gap >= 0);
  endtask

  function automatic logic [NREQ-1:0] model_gnt();
    return (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge RESET_N);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        chk("gnt", 32'(GNT), 32'(model_gnt()));
        chk("hold", 32'(HOLD), 32'(m_hold));
        chk("busy", 32'(BUSY), 32'(m_busy));
        chk("err", 32'(ERR), 32'(m_err));
        chk("timeout", 32'(TIMEOUT), 32'(m_to));
        chk("gnt_onehot", 32'($countones(GNT) <= 1), 32'(1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int gcnt[NREQ];
  int hlen[NREQ];

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_gnt(input string name, input logic [NREQ-1:0] mask);
    int n;
    n = 0;
    while (GNT == '0 && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(GNT), 32'(mask));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(BUSY), 32'(0));
  endtask

  // Masters: hold REQ for hlen granted cycles, drop, and later re-request.
  task automatic masters_step(input bit rnd);
    for (int i = 0; i < NREQ; i++) begin
      if (bit_of(req, i)) begin
        if (bit_of(GNT, i)) begin
          gcnt[i]++;
          if (gcnt[i] >= hlen[i]) begin
            req = req & ~(NREQ'(1) << i);
            gcnt[i] = 0;
          end
        end else if (gcnt[i] > 0) begin
          req = req & ~(NREQ'(1) << i);
          gcnt[i] = 0;
        end else if (rnd && $urandom_range(0, 30) == 0) begin
          req = req & ~(NREQ'(1) << i);
        end
      end else if (!rnd || $urandom_range(0, 5) == 0) begin
        req = req | (NREQ'(1) << i);
        gcnt[i] = 0;
        hlen[i] = rnd ? int'($urandom_range(1, 12)) : 5;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit gnt_seen;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] exp_g;
    int fl;

    for (int i = 0; i < NREQ; i++) begin
      gcnt[i] = 0;
      hlen[i] = 5;
    end
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_gnt", 32'(GNT), 32'(0));
    chk("rst_hold", 32'(HOLD), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_err", 32'(ERR), 32'(0));
    chk("rst_timeout", 32'(TIMEOUT), 32'(0));
    RESET_N = 1'b1;
    step(); step();

    // Single master 1, CPU answers 3 cycles after HOLD.
    req = 4'b0010;
    step();
    chk("t2_hold_up", 32'(HOLD), 32'(1));
    chk("t2_busy", 32'(BUSY), 32'(1));
    step(); step();
    chk("t2_hlda_up", 32'(hlda), 32'(1));
    chk("t2_no_gnt_yet", 32'(GNT), 32'(0));
    step();
    chk("t2_gnt", 32'(GNT), 32'(4'b0010));
    chk("t2_model_gnt", 32'(model_gnt()), 32'(4'b0010));
    step(); step();
    req = 4'b0000;
    step();
    chk("t2_gnt_drop", 32'(GNT), 32'(0));
    chk("t2_hold_drop", 32'(HOLD), 32'(0));
    req = 4'b0010;
    n = 0;
    while (!HOLD && n < 12) begin
      step();
      n++;
    end
    chk("t2_cpu_window", 32'(n), 32'(4));
    wait_gnt("t2_regrant", 4'b0010);
    req = 4'b0000;
    wait_idle("t2_idle");

    // Withdraw: REQ[2] pulsed for one cycle in IDLE.
    req = 4'b0100;
    step();
    req = 4'b0000;
    chk("t4_hold_up", 32'(HOLD), 32'(1));
    n = 0;
    gnt_seen = 1'b0;
    while (HOLD && n < 12) begin
      step();
      n++;
      if (GNT != '0) gnt_seen = 1'b1;
    end
    chk("t4_hold_until_hlda", 32'(n), 32'(3));
    chk("t4_no_gnt", 32'(gnt_seen), 32'(0));
    wait_idle("t4_idle");
    // ptr must still be 2: with masters 0 and 2 asking, 2 wins.
    req = 4'b0101;
    wait_gnt("t4_ptr_kept", 4'b0100);

    // Protocol error: HLDA forced low while master 2 is granted.
    force_low = 1'b1;
    step();
    chk("t5_gnt_before", 32'(GNT), 32'(4'b0100));
    step();
    chk("t5_err", 32'(ERR), 32'(1));
    chk("t5_gnt_off", 32'(GNT), 32'(0));
    chk("t5_hold_off", 32'(HOLD), 32'(0));
    chk("t5_model_err", 32'(m_err), 32'(1));
    step();
    chk("t5_err_once", 32'(ERR), 32'(0));
    chk("t5_busy", 32'(BUSY), 32'(1));
    force_low = 1'b0;
    step();
    chk("t5_gap_busy", 32'(BUSY), 32'(1));
    // ptr advanced past 2, so master 0 wins over master 2.
    wait_gnt("t5_ptr_advanced", 4'b0001);

    // Reset asserted mid-grant.
    RESET_N = 1'b0;
    #1;
    chk("t1_async_gnt", 32'(GNT), 32'(0));
    chk("t1_async_hold", 32'(HOLD), 32'(0));
    chk("t1_async_busy", 32'(BUSY), 32'(0));
    req = 4'b0000;
    step(); step();
    RESET_N = 1'b1;
    step(); step(); step();
    chk("t1_quiet_gnt", 32'(GNT), 32'(0));
    chk("t1_quiet_hold", 32'(HOLD), 32'(0));

    // Round-robin with all four requesting.
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      gcnt[i] = 0;
      hlen[i] = 5;
    end
    prev = '0;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      step();
      n++;
      if (GNT != '0 && prev == '0) begin
        exp_g = exp_q.pop_front();
        chk("t3_rr_order", 32'(GNT), 32'(exp_g));
      end
      prev = GNT;
      masters_step(1'b0);
    end
    chk("t3_all_grants_seen", 32'(exp_q.size()), 32'(0));
    req = 4'b0000;
    wait_idle("t3_idle");

`ifdef BUS_TENURE_LIMIT_EN
    // Tenure limit: master 0 never lets go, master 1 waits.
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    req = 4'b0011;
    wait_gnt("t6_first", 4'b0001);
    n = 1;
    while (GNT[0] && n < 40) begin
      step();
      if (GNT[0]) n++;
    end
    chk("t6_gnt_len", 32'(n), 32'(MAXH));
    chk("t6_timeout", 32'(TIMEOUT), 32'(1));
    req = 4'b0010;
    wait_gnt("t6_next_master", 4'b0010);
    req = 4'b0000;
    wait_idle("t6_idle");
`endif

    // Random traffic with random CPU latency and occasional HLDA faults.
    cpu_rand = 1'b1;
    fl = 0;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      masters_step(1'b1);
      if (fl > 0) begin
        fl--;
        if (fl == 0) force_low = 1'b0;
      end else if (GNT != '0 && $urandom_range(0, 80) == 0) begin
        force_low = 1'b1;
        fl = 2;
      end
    end
    force_low = 1'b0;
    req = 4'b0000;
    wait_idle("rand_idle");
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
